// File: rtl/count_pulse_gen.sv
// rtl/count_pulse_gen.sv - one-second prescaler plus arbitrated inc/dec pulse generator
// Feeds a downstream up/down counter one spaced pulse at a time.
module count_pulse_gen #(
    parameter int TICK_DIV   = 31_500_000,
    parameter int GAP_CYCLES = 1,
    parameter int BONUS_MAX  = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       bonus_req,
    input  logic [3:0] bonus_amount,
    input  logic       penalty_req,
    input  logic       time_up,
    output logic       increment,
    output logic       decrement,
    output logic       sec_tick,
    output logic       busy,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0]    GAP_LAST = 3'(GAP_CYCLES - 1);
    localparam logic [5:0]    SAT_WIDE = 6'(BONUS_MAX);
    localparam logic [4:0]    SAT_CNT  = 5'(BONUS_MAX);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;
    typedef enum logic [1:0] {K_TICK, K_PEN, K_BONUS} kind_t;

    state_t        state, state_n, launch_state;
    kind_t         kind, kind_n, launch_kind;
    logic [2:0]    gap_cnt, gap_n;
    logic [PW-1:0] prescaler;
    logic          tick_pend, pen_pend, pen_d;
    logic [4:0]    bonus_cnt;
    logic [5:0]    bonus_sum;
    logic          counting, tick_set, pen_rise, pending;
    logic          take_tick, take_pen, take_bonus;

    assign counting   = run && !done;
    assign tick_set   = counting && (prescaler == PRE_LAST);
    assign pen_rise   = penalty_req && !pen_d;
    assign pending    = tick_pend || pen_pend || (bonus_cnt != 5'd0);
    assign take_tick  = (state == PULSE) && (kind == K_TICK);
    assign take_pen   = (state == PULSE) && (kind == K_PEN);
    assign take_bonus = (state == PULSE) && (kind == K_BONUS);
    assign bonus_sum  = {1'b0, bonus_cnt} + {2'b00, bonus_amount} - {5'd0, take_bonus};
    assign busy       = ((state != IDLE) && (state != DONE)) || pending;

    // Prescaler only advances while playing, so pausing keeps the sub-second phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            sec_tick  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (counting) begin
                if (prescaler == PRE_LAST) begin
                    prescaler <= '0;
                    sec_tick  <= 1'b1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_pend <= 1'b0;
            pen_pend  <= 1'b0;
            pen_d     <= 1'b0;
            bonus_cnt <= 5'd0;
            done      <= 1'b0;
        end else begin
            pen_d <= penalty_req;
            if (time_up) begin
                tick_pend <= 1'b0;
                pen_pend  <= 1'b0;
                bonus_cnt <= 5'd0;
                done      <= 1'b1;
            end else begin
                if (tick_set)
                    tick_pend <= 1'b1;
                else if (take_tick)
                    tick_pend <= 1'b0;
                if (pen_rise && !done)
                    pen_pend <= 1'b1;
                else if (take_pen)
                    pen_pend <= 1'b0;
                // bonus_sum already folds in the increment consumed this cycle
                if (bonus_req && !done)
                    bonus_cnt <= (bonus_sum > SAT_WIDE) ? SAT_CNT : bonus_sum[4:0];
                else if (take_bonus)
                    bonus_cnt <= bonus_cnt - 5'd1;
            end
        end
    end

    always_comb begin
        launch_state = IDLE;
        launch_kind  = kind;
        if (done) begin
            launch_state = DONE;
        end else if (run && pending) begin
            launch_state = PULSE;
            if (tick_pend)
                launch_kind = K_TICK;
            else if (pen_pend)
                launch_kind = K_PEN;
            else
                launch_kind = K_BONUS;
        end
    end

    // The last GAP cycle makes the IDLE decision itself, giving a pulse/gap cadence.
    always_comb begin
        state_n   = state;
        kind_n    = kind;
        gap_n     = gap_cnt;
        increment = 1'b0;
        decrement = 1'b0;
        case (state)
            IDLE: begin
                state_n = launch_state;
                kind_n  = launch_kind;
            end
            PULSE: begin
                increment = (kind == K_BONUS);
                decrement = (kind != K_BONUS);
                state_n   = GAP;
                gap_n     = 3'd0;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = launch_state;
                    kind_n  = launch_kind;
                end else begin
                    gap_n = gap_cnt + 3'd1;
                end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (time_up)
            state_n = DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            kind    <= K_TICK;
            gap_cnt <= 3'd0;
        end else begin
            state   <= state_n;
            kind    <= kind_n;
            gap_cnt <= gap_n;
        end
    end

endmodule

// File: tb/tb_count_pulse_gen.sv
// tb/tb_count_pulse_gen.sv - scoreboard bench for count_pulse_gen (TICK_DIV=8, GAP_CYCLES=1)
module tb_count_pulse_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       bonus_req = 1'b0;
    logic [3:0] bonus_amount = 4'd0;
    logic       penalty_req = 1'b0;
    logic       time_up = 1'b0;
    logic       increment, decrement, sec_tick, busy, done;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int exp_kind[$];
    int exp_cyc[$];
    int tick_q[$];
    int last_pulse = -10;
    int c0;

    count_pulse_gen #(.TICK_DIV(8), .GAP_CYCLES(1), .BONUS_MAX(31)) dut (
        .clk(clk), .reset(reset), .run(run), .bonus_req(bonus_req),
        .bonus_amount(bonus_amount), .penalty_req(penalty_req), .time_up(time_up),
        .increment(increment), .decrement(decrement), .sec_tick(sec_tick),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse seen must match the head of the expectation queues.
    always @(negedge clk) begin
        if (increment || decrement) begin
            checks++;
            if (increment && decrement) begin
                failures++;
                $display("FAIL both_high cyc=%0d inc=%0b dec=%0b required exactly one", cyc, increment, decrement);
            end
            checks++;
            if (cyc == last_pulse + 1) begin
                failures++;
                $display("FAIL adjacent_pulse cyc=%0d previous=%0d required a gap", cyc, last_pulse);
            end
            last_pulse = cyc;
            checks++;
            if (exp_kind.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d inc=%0b required no pulse", cyc, increment);
            end else begin
                automatic int k = exp_kind.pop_front();
                automatic int c = exp_cyc.pop_front();
                if (int'(increment) != k || cyc != c) begin
                    failures++;
                    $display("FAIL pulse got inc=%0b at cyc=%0d required inc=%0d at cyc=%0d", increment, cyc, k, c);
                end
            end
        end
        if (sec_tick) begin
            checks++;
            if (tick_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_sec_tick cyc=%0d required none", cyc);
            end else begin
                automatic int c = tick_q.pop_front();
                if (cyc != c) begin
                    failures++;
                    $display("FAIL sec_tick got cyc=%0d required cyc=%0d", cyc, c);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic push(input int k, input int c);
        exp_kind.push_back(k);
        exp_cyc.push_back(c);
    endtask

    task automatic drained(input string name);
        chk({name, "_pulses_left"}, exp_kind.size(), 0);
        chk({name, "_ticks_left"}, tick_q.size(), 0);
        chk({name, "_busy_end"}, int'(busy), 0);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_inc", int'(increment), 0);
        chk("rst_dec", int'(decrement), 0);
        chk("rst_tick", int'(sec_tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        // steady run: tick every 8, decrement one cycle after each
        c0 = cyc;
        run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick_q.push_back(c0 + 8 * k);
            push(0, c0 + 8 * k + 1);
        end
        wait_to(c0 + 41);
        run = 1'b0;
        wait_to(c0 + 44);
        drained("run40");

        // bonus of 3: inc every 2 cycles, busy drops after the last gap
        do_reset();
        c0 = cyc;
        run = 1'b1; bonus_req = 1'b1; bonus_amount = 4'd3;
        push(1, c0 + 2); push(1, c0 + 4); push(1, c0 + 6);
        wait_to(c0 + 1);
        bonus_req = 1'b0;
        wait_to(c0 + 6);
        run = 1'b0;
        wait_to(c0 + 7);
        chk("bonus3_busy_in_gap", int'(busy), 1);
        wait_to(c0 + 8);
        drained("bonus3");

        // tick, penalty edge and bonus of 2 pending together
        do_reset();
        c0 = cyc;
        run = 1'b1;
        wait_to(c0 + 7);
        penalty_req = 1'b1; bonus_req = 1'b1; bonus_amount = 4'd2;
        tick_q.push_back(c0 + 8);
        push(0, c0 + 9); push(0, c0 + 11); push(1, c0 + 13); push(1, c0 + 15);
        wait_to(c0 + 8);
        bonus_req = 1'b0;
        wait_to(c0 + 15);
        run = 1'b0; penalty_req = 1'b0;
        wait_to(c0 + 17);
        drained("mixed");

        // 3 x 15 saturates at 31; ticks interleave as every 4th slot
        do_reset();
        c0 = cyc;
        bonus_req = 1'b1; bonus_amount = 4'd15;
        wait_to(c0 + 3);
        bonus_req = 1'b0;
        chk("sat_held_busy", int'(busy), 1);
        run = 1'b1;
        for (int n = 0; n < 40; n++)
            push((n >= 4 && n % 4 == 0) ? 0 : 1, c0 + 4 + 2 * n);
        for (int m = 1; m <= 9; m++)
            tick_q.push_back(c0 + 3 + 8 * m);
        wait_to(c0 + 82);
        run = 1'b0;
        wait_to(c0 + 84);
        drained("sat31");

        // pause at prescaler=5 for 20 cycles, tick 3 cycles after resume
        do_reset();
        c0 = cyc;
        run = 1'b1;
        wait_to(c0 + 5);
        run = 1'b0;
        wait_to(c0 + 25);
        chk("pause_busy", int'(busy), 0);
        run = 1'b1;
        tick_q.push_back(c0 + 28);
        push(0, c0 + 29);
        wait_to(c0 + 29);
        run = 1'b0;
        wait_to(c0 + 32);
        drained("pause");

        // time_up with bonus pending, requests then ignored
        do_reset();
        c0 = cyc;
        bonus_req = 1'b1; bonus_amount = 4'd4;
        wait_to(c0 + 1);
        bonus_req = 1'b0; time_up = 1'b1;
        chk("tu_busy_before", int'(busy), 1);
        wait_to(c0 + 2);
        time_up = 1'b0; run = 1'b1;
        chk("tu_done", int'(done), 1);
        chk("tu_busy_cleared", int'(busy), 0);
        wait_to(c0 + 3);
        bonus_req = 1'b1; bonus_amount = 4'd5; penalty_req = 1'b1;
        wait_to(c0 + 4);
        bonus_req = 1'b0;
        wait_to(c0 + 20);
        chk("tu_done_sticky", int'(done), 1);
        drained("tu_ignored");

        // reset with penalty_req held high counts as one edge
        do_reset();
        c0 = cyc;
        chk("tu_done_after_reset", int'(done), 0);
        push(0, c0 + 2);
        wait_to(c0 + 2);
        run = 1'b0;
        wait_to(c0 + 5);
        penalty_req = 1'b0;
        chk("resume_done", int'(done), 0);
        drained("resume");

        // reset during PULSE aborts the remaining bonus
        do_reset();
        c0 = cyc;
        run = 1'b1; bonus_req = 1'b1; bonus_amount = 4'd3;
        push(1, c0 + 2);
        wait_to(c0 + 1);
        bonus_req = 1'b0;
        wait_to(c0 + 2);
        reset = 1'b1;
        wait_to(c0 + 3);
        reset = 1'b0; run = 1'b0;
        chk("abort_inc", int'(increment), 0);
        chk("abort_dec", int'(decrement), 0);
        chk("abort_busy", int'(busy), 0);
        wait_to(c0 + 10);
        drained("abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_pulse_gen.md
COUNT_PULSE_GEN -- requirements
Module: count_pulse_gen

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
- TICK_DIV, default 31_500_000: clk cycles per one-second tick.
- GAP_CYCLES, default 1: idle cycles forced after every output pulse (legal range 1..7).
- BONUS_MAX, default 31: saturation value of the bonus queue.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- run  in  1  level; game in PLAY.
- bonus_req  in  1  one-cycle pulse; queue bonus_amount increments.
- bonus_amount  in  4  number of increments to queue on bonus_req.
- penalty_req  in  1  level; each rising edge requests one decrement.
- time_up  in  1  one-cycle pulse from the downstream counter when it reaches 000.
- increment  out  1  one-cycle +1 pulse to the downstream counter.
- decrement  out  1  one-cycle -1 pulse to the downstream counter.
- sec_tick  out  1  one-cycle pulse when the prescaler wraps.
- busy  out  1  high when any request is pending or the FSM is not IDLE.
- done  out  1  sticky; high after time_up.

Function
REQ-004 The prescaler SHALL count 0..TICK_DIV-1 only while run=1 and done=0, and hold its value otherwise, so the phase is kept across pause.
REQ-005 On the cycle the prescaler goes from TICK_DIV-1 to 0, the block SHALL pulse sec_tick for one cycle and set the sticky flag tick_pend.
- If tick_pend is already set, it stays 1 and the extra tick is dropped.
REQ-006 A rising edge of penalty_req (registered edge detect, 1-cycle delay) SHALL set the sticky flag pen_pend.
- A second edge while pen_pend=1 is dropped.
REQ-007 On bonus_req=1, bonus_cnt (5 bits) SHALL become min(bonus_cnt + bonus_amount, BONUS_MAX).
- If an increment is consumed in the same cycle, the result is min(bonus_cnt + bonus_amount - 1, BONUS_MAX).
- bonus_amount=0 is a no-op.
REQ-008 Requests SHALL be accepted in every cycle regardless of run, and SHALL be held while run=0.
REQ-009 The FSM SHALL have the states IDLE, PULSE, GAP and DONE.
REQ-010 Transitions out of IDLE, in priority order:
- done=1 -> DONE.
- Otherwise, if run=1 and any request is pending -> PULSE, latching the kind by priority: tick_pend (dec) > pen_pend (dec) > bonus_cnt!=0 (inc).
- Otherwise stay in IDLE.
REQ-011 In PULSE, the block SHALL assert exactly one of increment/decrement for exactly one cycle.
- In the same cycle it clears the consumed flag, or decrements bonus_cnt.
- Next state is GAP.
REQ-012 GAP SHALL last GAP_CYCLES cycles and then return to IDLE.
REQ-013 increment and decrement SHALL never be high in the same cycle, and neither SHALL be high in two consecutive cycles.
REQ-014 Latency: a request pending at a rising edge while the FSM is IDLE and run=1 SHALL produce its output pulse during the next cycle.
REQ-015 run falling while in PULSE or GAP SHALL let the current pulse and gap complete; no new pulse starts until run=1.
REQ-016 time_up SHALL set done.
- In the same cycle it clears tick_pend, pen_pend and bonus_cnt.
- The FSM goes to DONE from any state; a PULSE already being output in that cycle completes.
REQ-017 In DONE, outputs increment and decrement SHALL stay 0, and new requests SHALL be ignored until reset.
REQ-018 busy SHALL be combinational: (state!=IDLE && state!=DONE) || tick_pend || pen_pend || bonus_cnt!=0.

Reset
REQ-019 While reset=1 at a rising edge, the block SHALL clear all outputs to 0 and clear the prescaler, tick_pend, pen_pend, bonus_cnt and the edge-detect register.
- The FSM goes to IDLE and done to 0.
REQ-020 Reset asserted mid-PULSE or mid-GAP SHALL abort the operation, and no pulse SHALL appear in the cycle after reset.
REQ-021 After reset the edge-detect register is 0, so a penalty_req already high when reset is released SHALL count as one rising edge.

Verification (TICK_DIV=8, GAP_CYCLES=1)
REQ-022 The bench SHALL cover: run=1 for 40 cycles -> sec_tick every 8 cycles, each followed one cycle later by a single decrement; 5 decrements total.
REQ-023 The bench SHALL cover: bonus_req with bonus_amount=3 while run=1 -> increment pulses 2 cycles apart (1 pulse, 1 gap), 3 in total, busy low after the last GAP.
REQ-024 The bench SHALL cover: sec_tick, penalty edge and a bonus of 2 all pending in the same cycle -> order dec(tick), dec(penalty), inc, inc, never adjacent.
REQ-025 The bench SHALL cover: bonus_amount=15 three times back-to-back -> bonus_cnt saturates at 31, and exactly 31 increments follow.
REQ-026 The bench SHALL cover: run=0 for 20 cycles at prescaler=5 -> no pulses and the prescaler is held; after run=1, sec_tick occurs 3 cycles later.
REQ-027 The bench SHALL cover: time_up with a bonus of 4 pending -> done=1, zero further increments, and requests ignored; after reset, done=0 and normal operation resumes.
